// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and bit-offset helpers for the convolution
// sequencer.
package conv_pkg;

  localparam int IMG   = 12;
  localparam int K     = 3;
  localparam int PIX_W = 2;
  localparam int NFILT = 4;
  localparam int ACC_W = 8;

  localparam int OUT  = IMG - K + 1;
  localparam int NRES = NFILT * OUT * OUT;
  localparam int FW   = $clog2(NFILT);
  localparam int CW   = $clog2(IMG);

  localparam int IMG_BITS  = IMG * IMG * PIX_W;
  localparam int FILT_BITS = NFILT * K * K * PIX_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  function automatic int pix_off(input int r, input int c);
    return (r * IMG + c) * PIX_W;
  endfunction

  function automatic int tap_off(input int f, input int i, input int j);
    return ((f * K + i) * K + j) * PIX_W;
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Frame request, status and result stream between the sequencer and the
// downstream pooling/packing stage.
interface conv_sched_if;
  import conv_pkg::*;

  logic                 start;
  logic [IMG_BITS-1:0]  img_in;
  logic [FILT_BITS-1:0] filt_in;
  logic                 busy;
  logic                 done;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_W-1:0]     res_data;
  logic [FW-1:0]        res_filt;
  logic [CW-1:0]        res_row;
  logic [CW-1:0]        res_col;

  modport master (
    output start, img_in, filt_in, res_ready,
    input  busy, done, res_valid, res_data, res_filt, res_row, res_col
  );

  modport slave (
    input  start, img_in, filt_in, res_ready,
    output busy, done, res_valid, res_data, res_filt, res_row, res_col
  );

endinterface

// File: rtl/conv_mac3x3.sv
// Combinational 3x3 multiply-accumulate: nine unsigned products summed
// through a balanced adder tree, zero-extended to the result width.
module conv_mac3x3
  import conv_pkg::*;
(
  input  logic [K*K-1:0][PIX_W-1:0] pix_i,
  input  logic [K*K-1:0][PIX_W-1:0] w_i,
  output logic [ACC_W-1:0]          sum_o
);

  localparam int PW = 2 * PIX_W;
  localparam int SW = PW + 4;

  logic [SW-1:0] prod [K*K];
  logic [SW-1:0] s0, s1, s2, s3, t0, t1, tot;

  always_comb begin
    for (int k = 0; k < K * K; k++) begin
      prod[k] = SW'(pix_i[k]) * SW'(w_i[k]);
    end
  end

  assign s0  = prod[0] + prod[1];
  assign s1  = prod[2] + prod[3];
  assign s2  = prod[4] + prod[5];
  assign s3  = prod[6] + prod[7];
  assign t0  = s0 + s1;
  assign t1  = s2 + s3;
  assign tot = t0 + t1 + prod[8];

  assign sum_o = ACC_W'(tot);

endmodule

// File: rtl/conv_sched.sv
// Sequencer sharing one 3x3 MAC over every filter/window of a latched frame,
// streaming one result per valid/ready handshake.
module conv_sched
  import conv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.slave  bus
);

  state_e               state_q;
  logic [IMG_BITS-1:0]  img_q;
  logic [FILT_BITS-1:0] filt_q;
  logic [FW-1:0]        f_q;
  logic [CW-1:0]        r_q, c_q;
  logic                 busy_q, done_q, vld_q;
  logic [ACC_W-1:0]     data_q;
  logic [FW-1:0]        fidx_q;
  logic [CW-1:0]        row_q, col_q;

  logic [K*K-1:0][PIX_W-1:0] win, taps;
  logic [ACC_W-1:0]          mac_d;
  logic                      issue;

  // Window mux: pick the KxK pixels at (r,c) and the taps of filter f.
  always_comb begin
    win  = '0;
    taps = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[i*K+j]  = img_q[pix_off(int'(r_q) + i, int'(c_q) + j) +: PIX_W];
        taps[i*K+j] = filt_q[tap_off(int'(f_q), i, j) +: PIX_W];
      end
    end
  end

  conv_mac3x3 u_mac (
    .pix_i (win),
    .w_i   (taps),
    .sum_o (mac_d)
  );

  assign issue = !vld_q || bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      img_q   <= '0;
      filt_q  <= '0;
      f_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      fidx_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            img_q   <= bus.img_in;
            filt_q  <= bus.filt_in;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            data_q <= mac_d;
            fidx_q <= f_q;
            row_q  <= r_q;
            col_q  <= c_q;
            vld_q  <= 1'b1;
            // Column is the fastest index, then row, then filter.
            if (c_q == CW'(OUT - 1)) begin
              c_q <= '0;
              if (r_q == CW'(OUT - 1)) begin
                r_q <= '0;
                if (f_q == FW'(NFILT - 1)) begin
                  f_q     <= '0;
                  state_q <= FLUSH;
                end else begin
                  f_q <= f_q + 1'b1;
                end
              end else begin
                r_q <= r_q + 1'b1;
              end
            end else begin
              c_q <= c_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (vld_q && bus.res_ready) begin
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_valid = vld_q;
  assign bus.res_data  = data_q;
  assign bus.res_filt  = fidx_q;
  assign bus.res_row   = row_q;
  assign bus.res_col   = col_q;

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched: a frame-level reference model predicts
// every output each cycle; literal expectations pin selected frames.
module tb_conv_sched;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sched_if bus ();

  conv_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int lit_mode = 0;

  // Reference model: frame latched on acceptance, results indexed 0..NRES-1.
  logic                 m_busy = 1'b0;
  logic                 m_vld  = 1'b0;
  logic                 m_done = 1'b0;
  int                   m_idx  = 0;
  logic [IMG_BITS-1:0]  m_img  = '0;
  logic [FILT_BITS-1:0] m_filt = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pixel_of(input logic [IMG_BITS-1:0] img, input int r, input int c);
    return int'(img[(r * IMG + c) * PIX_W +: PIX_W]);
  endfunction

  function automatic int weight_of(input logic [FILT_BITS-1:0] fb, input int f, input int i, input int j);
    return int'(fb[((f * K + i) * K + j) * PIX_W +: PIX_W]);
  endfunction

  function automatic int exp_sum(input int idx);
    int f, r, c, s;
    f = idx / (OUT * OUT);
    r = (idx / OUT) % OUT;
    c = idx % OUT;
    s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += pixel_of(m_img, r + i, c + j) * weight_of(m_filt, f, i, j);
    return s % (1 << ACC_W);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          m_vld  <= 1'b0;
          m_idx  <= 0;
          m_img  <= bus.img_in;
          m_filt <= bus.filt_in;
        end
      end else if (!m_vld) begin
        m_vld <= 1'b1;
        m_idx <= 0;
      end else if (bus.res_ready) begin
        if (m_idx == NRES - 1) begin
          m_vld  <= 1'b0;
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  // Compare process plus handshake/done bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      int r, c, f, lit;
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      chk("res_valid", int'(bus.res_valid), int'(m_vld));
      if (m_vld) begin
        f = m_idx / (OUT * OUT);
        r = (m_idx / OUT) % OUT;
        c = m_idx % OUT;
        chk("res_data", int'(bus.res_data), exp_sum(m_idx));
        chk("res_filt", int'(bus.res_filt), f);
        chk("res_row", int'(bus.res_row), r);
        chk("res_col", int'(bus.res_col), c);
        case (lit_mode)
          1: chk("lit_all3", int'(bus.res_data), 81);
          2: chk("lit_zero", int'(bus.res_data), 0);
          3: begin
            case (f)
              0: lit = pixel_of(bus.img_in, r + 1, c + 1);
              1: lit = pixel_of(bus.img_in, r, c + 1);
              2: lit = pixel_of(bus.img_in, r + 2, c + 1);
              default: lit = pixel_of(bus.img_in, r + 1, c + 2);
            endcase
            chk("lit_identity", int'(bus.res_data), lit);
          end
          default: ;
        endcase
      end
      if (bus.res_valid && bus.res_ready) hs_cnt <= hs_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
    end
  end

  function automatic logic [IMG_BITS-1:0] rand_img();
    logic [IMG_BITS-1:0] v;
    for (int i = 0; i < IMG_BITS; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [FILT_BITS-1:0] rand_filt();
    logic [FILT_BITS-1:0] v;
    for (int i = 0; i < FILT_BITS; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_data"}, int'(bus.res_data), 0);
    chk({tag, "_filt"}, int'(bus.res_filt), 0);
    chk({tag, "_row"}, int'(bus.res_row), 0);
    chk({tag, "_col"}, int'(bus.res_col), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_frame(input int hb, input int db, input bit bp,
                            input int mid_at, input int rst_at);
    bit fired = 1'b0;
    bit fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      bus.res_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_at >= 0 && !fired && hs_cnt - hb == mid_at) begin
        bus.start  = 1'b1;
        bus.img_in = rand_img();
        fired = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (rst_at >= 0 && hs_cnt - hb == rst_at) begin
        #2 rst = 1'b1;
        #1 check_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        chk("no_done_on_abort", done_cnt - db, 0);
        return;
      end
      @(negedge clk); #1;
      if (done_cnt != db) fin = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    chk("frame_done_seen", int'(fin), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("result_count", hs_cnt - hb, NRES);
    chk("done_pulses", done_cnt - db, 1);
  endtask

  task automatic run_frame(input bit bp, input int mid_at, input int rst_at);
    int hb, db;
    hb = hs_cnt;
    db = done_cnt;
    pulse_start();
    wait_frame(hb, db, bp, mid_at, rst_at);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FILT_BITS-1:0] fb;
    int hb, db;
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    bus.img_in = '0;
    bus.filt_in = '0;

    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    // Identity filters over a random image.
    fb = '0;
    fb[tap_off(0, 1, 1) +: PIX_W] = PIX_W'(1);
    fb[tap_off(1, 0, 1) +: PIX_W] = PIX_W'(1);
    fb[tap_off(2, 2, 1) +: PIX_W] = PIX_W'(1);
    fb[tap_off(3, 1, 2) +: PIX_W] = PIX_W'(1);
    bus.filt_in = fb;
    bus.img_in = rand_img();
    lit_mode = 3;
    run_frame(1'b0, -1, -1);

    // Maximum operands everywhere.
    bus.img_in = '1;
    bus.filt_in = '1;
    lit_mode = 1;
    run_frame(1'b0, -1, -1);

    // Zero weights.
    bus.img_in = rand_img();
    bus.filt_in = '0;
    lit_mode = 2;
    run_frame(1'b0, -1, -1);
    lit_mode = 0;

    // Random data with backpressure.
    bus.img_in = rand_img();
    bus.filt_in = rand_filt();
    run_frame(1'b1, -1, -1);

    // Start pulse with new image mid-frame must be ignored.
    bus.img_in = rand_img();
    bus.filt_in = rand_filt();
    run_frame(1'b0, 50, -1);

    // Reset mid-frame, then a full fresh frame.
    bus.img_in = rand_img();
    bus.filt_in = rand_filt();
    run_frame(1'b0, -1, 123);
    bus.img_in = rand_img();
    run_frame(1'b1, -1, -1);

    // Start coinciding with the final handshake is ignored; one later is taken.
    bus.img_in = rand_img();
    bus.filt_in = rand_filt();
    hb = hs_cnt;
    pulse_start();
    bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 1000 && hs_cnt - hb < NRES; cyc++) begin
      @(negedge clk); #1;
    end
    chk("pre_done_count", hs_cnt - hb, NRES);
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("done_edge_done", int'(bus.done), 1);
    chk("done_edge_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_valid_early", int'(bus.res_valid), 0);
    @(posedge clk); #1;
    chk("restart_valid", int'(bus.res_valid), 1);
    chk("restart_row", int'(bus.res_row), 0);
    chk("restart_col", int'(bus.res_col), 0);
    chk("restart_filt", int'(bus.res_filt), 0);
    hb = hs_cnt;
    db = done_cnt;
    wait_frame(hb, db, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
